// File: rtl/mrv32_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiplier and restoring
// divider sharing one accumulator and one XLEN-cycle iteration counter.
module mrv32_muldiv #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_op1,
  input  logic [XLEN-1:0]  in_op2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready high
  // CALC  | seed cycle, then XLEN shift-add / trial-subtract iterations
  // FIX   | sign correction and result word select
  // DONE  | result presented, waiting for out_ready

  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic                seed_q;
  logic [2:0]          op_q;
  logic [TAG_W-1:0]    tag_q;
  logic [XLEN-1:0]     a_q, b_q;
  logic                s1_q, s2_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     res_q;
  logic [TAG_W-1:0]    otag_q;

  logic                accept;
  logic                s1_in, s2_in;
  logic                div0_in, ovf_in, fast_in;
  logic [XLEN-1:0]     fast_res;
  logic                last_iter;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = res_q;
  assign out_tag    = otag_q;

  assign accept = in_valid & in_ready & ~flush;

  // Request decode: signedness, divide-by-zero and signed overflow
  always_comb begin
    s1_in    = (in_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & in_op1[XLEN-1];
    s2_in    = (in_op inside {OP_MULH, OP_DIV, OP_REM}) & in_op2[XLEN-1];
    div0_in  = in_op[2] & (in_op2 == '0);
    ovf_in   = (in_op inside {OP_DIV, OP_REM}) &
               (in_op1 == {1'b1, {(XLEN-1){1'b0}}}) & (in_op2 == '1);
    fast_in  = div0_in | ovf_in;
    fast_res = '0;
    if (div0_in) fast_res = in_op[1] ? in_op1 : '1;
    else if (ovf_in) fast_res = in_op[1] ? '0 : in_op1;
  end

  assign last_iter = ~seed_q & (cnt_q == CW'(XLEN-1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = fast_in ? DONE : CALC;
      CALC: if (last_iter) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;
  logic [XLEN:0]       rem_sh, diff;
  logic [2*XLEN-1:0]   div_next;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem, mul_word, div_word, fix_res;

  always_comb begin
    a_mag    = s1_q ? -a_q : a_q;
    b_mag    = s2_q ? -b_q : b_q;

    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring step: the shifted partial remainder needs one extra bit
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, b_q};
    if (!diff[XLEN]) div_next = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else             div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    prod     = (s1_q ^ s2_q) ? -acc_q : acc_q;
    mul_word = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo      = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    if (op_q[1]) div_word = s1_q ? -rem : rem;
    else         div_word = (s1_q ^ s2_q) ? -quo : quo;
    fix_res  = op_q[2] ? div_word : mul_word;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      seed_q  <= 1'b0;
      op_q    <= '0;
      tag_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      acc_q   <= '0;
      res_q   <= '0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_q   <= in_op;
            tag_q  <= in_tag;
            a_q    <= in_op1;
            b_q    <= in_op2;
            s1_q   <= s1_in;
            s2_q   <= s2_in;
            cnt_q  <= '0;
            seed_q <= 1'b1;
            if (fast_in) begin
              res_q  <= fast_res;
              otag_q <= in_tag;
            end
          end
        end
        CALC: begin
          // Magnitudes are formed here so the accept path is only registers
          if (seed_q) begin
            acc_q  <= {{XLEN{1'b0}}, a_mag};
            b_q    <= b_mag;
            seed_q <= 1'b0;
          end else begin
            acc_q <= op_q[2] ? div_next : mul_next;
            cnt_q <= last_iter ? '0 : cnt_q + 1'b1;
          end
        end
        FIX: begin
          if (!flush) begin
            res_q  <= fix_res;
            otag_q <= tag_q;
          end
        end
        default: ;
      endcase
      if (flush) cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_mrv32_muldiv.sv
// Directed and randomised self-checking bench for mrv32_muldiv (XLEN=32).
module tb_mrv32_muldiv;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_op1, in_op2;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;
  exp_t exp_q[$];

  mrv32_muldiv #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sbv, ub, p;
    logic [63:0] up;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ub  = longint'({32'b0, b});
    case (op)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sbv; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sbv; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // One directed operation: accept, check latency boundary, result and tag, then drain
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                        input bit fast);
    chk({name, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_op1 = a; in_op2 = b; in_tag = tag;
    tick();
    in_valid = 1'b0; in_op1 = $urandom; in_op2 = $urandom; in_tag = 5'($urandom);
    if (!fast) begin
      repeat (33) tick();
      chk({name, "_early"}, 32'(out_valid), 32'd0);
      tick();
    end
    chk({name, "_vld"}, 32'(out_valid), 32'd1);
    chk({name, "_res"}, out_result, exp);
    chk({name, "_tag"}, 32'(out_tag), 32'(tag));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, "_drain"}, 32'({out_valid, in_ready}), 32'b01);
  endtask

  logic [2:0]  sw_op;
  logic [31:0] sw_a, sw_b;
  logic [4:0]  sw_tag;
  exp_t        sw_e;
  bit          got, seen;
  int          nres, wcnt, ccnt;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_op1 = '0; in_op2 = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_state", 32'({out_valid, in_ready}), 32'b01);
    chk("rst_res", out_result, 32'h0);
    chk("rst_tag", 32'(out_tag), 32'h0);
    rst = 1'b0;
    tick();

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 1'b0);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2, 32'h4000_0000, 1'b0);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, 1'b0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 1'b0);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5, 32'hFFFF_FFFD, 1'b0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6, 32'hFFFF_FFFF, 1'b0);
    run_op("divu",   3'd5, 32'd100,        32'd7,         5'd7, 32'd14,        1'b0);
    run_op("remu",   3'd7, 32'd100,        32'd7,         5'd8, 32'd2,         1'b0);
    run_op("divu0",  3'd5, 32'd5,          32'd0,         5'd9, 32'hFFFF_FFFF, 1'b1);
    run_op("remu0",  3'd7, 32'd5,          32'd0,        5'd10, 32'd5,         1'b1);
    run_op("div0",   3'd4, 32'd5,          32'd0,        5'd11, 32'hFFFF_FFFF, 1'b1);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF,5'd12, 32'h8000_0000, 1'b1);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF,5'd13, 32'h0,         1'b1);

    // Backpressure: result and tag held while out_ready is low
    in_valid = 1'b1; in_op = 3'd0; in_op1 = 32'd3; in_op2 = 32'd4; in_tag = 5'h1A;
    tick();
    in_valid = 1'b1; in_op1 = 32'd9; in_op2 = 32'd9; in_tag = 5'h03;
    repeat (34) tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_vld", 32'({out_valid, in_ready}), 32'b10);
      chk("bp_res", out_result, 32'd12);
      chk("bp_tag", 32'(out_tag), 32'h1A);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", 32'({out_valid, in_ready}), 32'b01);

    // Flush in IDLE blocks the accept of a fast-path op
    in_valid = 1'b1; in_op = 3'd5; in_op1 = 32'd5; in_op2 = 32'd0; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_idle", 32'({out_valid, in_ready}), 32'b01);

    // Flush in DONE discards the result
    in_valid = 1'b1; in_op = 3'd5; in_op1 = 32'd5; in_op2 = 32'd0; in_tag = 5'd14;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_done", 32'({out_valid, in_ready}), 32'b01);

    // Flush mid-CALC at count 10
    in_valid = 1'b1; in_op = 3'd5; in_op1 = 32'd1000; in_op2 = 32'd3; in_tag = 5'd15;
    tick();
    in_valid = 1'b0;
    repeat (11) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_calc", 32'({out_valid, in_ready}), 32'b01);
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
    chk("flush_noresult", 32'(seen), 32'd0);
    run_op("mul_after_flush", 3'd0, 32'd2, 32'd3, 5'd16, 32'd6, 1'b0);

    // Async reset mid-CALC
    in_valid = 1'b1; in_op = 3'd5; in_op1 = 32'd1000; in_op2 = 32'd3; in_tag = 5'd17;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'({out_valid, in_ready}), 32'b01);
    chk("arst_res", out_result, 32'h0);
    chk("arst_tag", 32'(out_tag), 32'h0);
    #2 rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
    chk("arst_noresult", 32'(seen), 32'd0);
    run_op("mul_after_rst", 3'd0, 32'd2, 32'd3, 5'd18, 32'd6, 1'b0);

    // Randomised sweep with output stalls and junk requests while busy
    nres = 0;
    for (int n = 0; n < 1000; n++) begin
      sw_op = 3'($urandom_range(0, 7));
      sw_a = pick_operand();
      sw_b = pick_operand();
      sw_tag = 5'($urandom);
      wcnt = 0;
      while (!in_ready && wcnt < 50) begin tick(); wcnt++; end
      if (!in_ready) chk("sw_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_op = sw_op; in_op1 = sw_a; in_op2 = sw_b; in_tag = sw_tag;
      tick();
      exp_q.push_back('{res: ref_model(sw_op, sw_a, sw_b), tag: sw_tag});
      in_valid = 1'($urandom_range(0, 1));
      in_op = 3'($urandom); in_op1 = $urandom; in_op2 = $urandom; in_tag = 5'($urandom);
      got = 1'b0;
      ccnt = 0;
      while (!got && ccnt < 200) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("sw_duplicate", 32'(exp_q.size()), 32'd1);
          end else begin
            sw_e = exp_q.pop_front();
            chk("sw_res", out_result, sw_e.res);
            chk("sw_tag", 32'(out_tag), 32'(sw_e.tag));
          end
          nres++;
          got = 1'b1;
        end
        tick();
        ccnt++;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      if (!got) chk("sw_timeout", 32'(got), 32'd1);
    end
    chk("sw_count", 32'(nres), 32'd1000);
    chk("sw_leftover", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
